// File: rtl/inv_mix_columns_seq.sv
// rtl/inv_mix_columns_seq.sv - iterative AES InvMixColumns, one 32-bit column per clock
// Optional macro INV_MIX_COLUMNS_FWD_SEL_EN adds in_fwd to select the forward MixColumns matrix.
module inv_mix_columns_seq #(
  parameter int NCOL = 6
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [32*NCOL-1:0]   in_data,
`ifdef INV_MIX_COLUMNS_FWD_SEL_EN
  input  logic                 in_fwd,
`endif
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [32*NCOL-1:0]   out_data
);

  localparam int W  = 32 * NCOL;
  localparam int CW = $clog2(NCOL);
  localparam logic [CW-1:0] LAST = CW'(NCOL - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]    r_state;
  logic [CW-1:0] r_cnt;
  logic [W-1:0]  r_work;
  logic [W-1:0]  w_work_nxt;
  logic [31:0]   w_col;
  logic [31:0]   w_col_new;
  logic          w_fwd;

  function automatic logic [7:0] xt(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
  endfunction

  // Row i uses the circulant matrix rows: coefficients rotate right by one per row.
  function automatic logic [31:0] mix_col(input logic [31:0] c, input logic fwd);
    logic [7:0]  a  [4];
    logic [7:0]  m2 [4];
    logic [7:0]  m3 [4];
    logic [7:0]  m4 [4];
    logic [7:0]  m8 [4];
    logic [7:0]  m9 [4];
    logic [7:0]  mb [4];
    logic [7:0]  md [4];
    logic [7:0]  me [4];
    logic [31:0] r;
    for (int i = 0; i < 4; i++) begin
      a[i]  = c[31-8*i -: 8];
      m2[i] = xt(a[i]);
      m4[i] = xt(m2[i]);
      m8[i] = xt(m4[i]);
      m3[i] = m2[i] ^ a[i];
      m9[i] = m8[i] ^ a[i];
      mb[i] = m8[i] ^ m2[i] ^ a[i];
      md[i] = m8[i] ^ m4[i] ^ a[i];
      me[i] = m8[i] ^ m4[i] ^ m2[i];
    end
    r = '0;
    for (int i = 0; i < 4; i++) begin
      r[31-8*i -: 8] = fwd ? (m2[i] ^ m3[(i+1)%4] ^ a[(i+2)%4] ^ a[(i+3)%4])
                           : (me[i] ^ mb[(i+1)%4] ^ md[(i+2)%4] ^ m9[(i+3)%4]);
    end
    return r;
  endfunction

`ifdef INV_MIX_COLUMNS_FWD_SEL_EN
  logic r_fwd;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fwd <= 1'b0;
    end else if (r_state == S_IDLE && in_valid) begin
      r_fwd <= in_fwd;
    end
  end

  assign w_fwd = r_fwd;
`else
  assign w_fwd = 1'b0;
`endif

  always_comb begin
    w_col = '0;
    for (int c = 0; c < NCOL; c++) begin
      if (r_cnt == CW'(c)) w_col = r_work[W-1-32*c -: 32];
    end
    w_col_new  = mix_col(w_col, w_fwd);
    w_work_nxt = r_work;
    for (int c = 0; c < NCOL; c++) begin
      if (r_cnt == CW'(c)) w_work_nxt[W-1-32*c -: 32] = w_col_new;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_work  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_work  <= in_data;
            r_cnt   <= '0;
            r_state <= S_BUSY;
          end
        end
        S_BUSY: begin
          r_work <= w_work_nxt;
          if (r_cnt == LAST) r_state <= S_DONE;
          else               r_cnt   <= r_cnt + 1'b1;
        end
        S_DONE: begin
          if (out_ready) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Gating keeps partially transformed blocks off the output bus.
  assign in_ready  = (r_state == S_IDLE);
  assign out_valid = (r_state == S_DONE);
  assign out_data  = out_valid ? r_work : '0;

endmodule

// File: doc/inv_mix_columns_seq.md
Name: inv_mix_columns_seq

Overview:
Iterative AES InvMixColumns engine: the decrypt-side counterpart of the combinational MixColumns datapath. It accepts a NCOL-column state block over a valid/ready handshake and applies the inverse column transform one 32-bit column per clock, using a single shared column unit. It returns the result over a second valid/ready handshake. It sits in the decryption round pipeline between InvShiftRows/InvSubBytes and AddRoundKey.

Parameters:
NCOL, 6, number of 32-bit columns per block. Supported values are 4 (128-bit) and 6 (192-bit); block width W = 32*NCOL.

Ports:
clk  in  1  clock; all state updates on the rising edge
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  input block valid
in_ready  out  1  engine can accept a block
in_data  in  W  input state; column 0 = in_data[W-1:W-32], column c = bits [W-1-32c : W-32-32c]; within a column, row 0 = [31:24] … row 3 = [7:0]
out_valid  out  1  result valid
out_ready  in  1  downstream accepts result
out_data  out  W  result state, same packing as in_data

Behaviour:
- Clock and reset: one clock (clk). Reset is asynchronous and active-low (rst_n).
- Reset values while rst_n=0: state=IDLE, column counter=0, working register=0, out_valid=0, out_data=0.
- in_ready = (state==IDLE). It is therefore 1 during and right after reset.
- State machine:
  - IDLE: on in_valid&&in_ready, latch in_data into the working register, clear counter to 0, go to BUSY. Otherwise stay.
  - BUSY: each cycle, replace column[counter] of the working register with InvMix(column[counter]) and increment the counter. On the cycle that processes column NCOL-1, go to DONE.
  - DONE: out_valid=1 and out_data=working register. On out_ready, go to IDLE. Otherwise hold; out_data must stay stable while out_valid&&!out_ready.
- Latency: accept handshake at edge t. Columns are processed at edges t+1 … t+NCOL. out_valid is high from edge t+NCOL.
- Throughput: at most one block per NCOL+2 cycles. in_ready is never high in BUSY or DONE, so no overlap.
- Column transform, GF(2^8) with modulus 0x11B:
  - r0' = 0e·r0 ^ 0b·r1 ^ 0d·r2 ^ 09·r3
  - r1' = 09·r0 ^ 0e·r1 ^ 0b·r2 ^ 0d·r3
  - r2' = 0d·r0 ^ 09·r1 ^ 0e·r2 ^ 0b·r3
  - r3' = 0b·r0 ^ 0d·r1 ^ 09·r2 ^ 0e·r3
  - Constants are built from xtime(x) = (x<<1)[7:0] ^ (x[7] ? 0x1B : 0x00), iterated for x4 and x8.
- Input handling: in_valid/in_data are ignored while in_ready=0. out_ready is ignored while out_valid=0.
- Counter: $clog2(NCOL) bits. It never exceeds NCOL-1 and does not wrap within a block.
- Reset mid-operation: asserting rst_n in BUSY or DONE aborts the block immediately. out_valid drops asynchronously and no partial result is ever presented.
- Simultaneous events: in DONE with out_ready=1, the next block cannot be accepted until the following cycle (IDLE).

Optional Feature:
Macro INV_MIX_COLUMNS_FWD_SEL_EN.
- Defined: adds input port in_fwd (1 bit), latched at the input handshake. in_fwd=1 applies the forward MixColumns matrix [02 03 01 01 / 01 02 03 01 / 01 01 02 03 / 03 01 01 02] instead, with the same timing, handshake and packing. in_fwd=0 applies the inverse.
- Not defined: port absent; the inverse transform is always applied.

Test Plan:
- NCOL=6. in_data={8e4da1bc,9fdc589d,01010101,c6c6c6c6,d5d5d7d6,4d7ebdf8} with out_ready=1 -> out_data={db135345,f20a225c,01010101,c6c6c6c6,d4d4d4d5,2d26314c}; out_valid rises exactly 6 edges after accept; in_ready low from accept until the out handshake.
- Backpressure: same block with out_ready=0 for 10 cycles -> out_valid stays 1, out_data unchanged. Raise out_ready -> one transfer, then in_ready=1 on the next cycle.
- Ignored input: toggle in_valid with new data while BUSY -> result equals the first block only; the second block is accepted only after the return to IDLE.
- Async reset: assert rst_n=0 at the 3rd BUSY cycle -> out_valid=0, out_data=0, in_ready=1 with no clock edge. After release, block all-00 -> result all-00.
- Back-to-back: two blocks (vector above, then all-c6) with in_valid and out_ready held high -> both results correct; accepts spaced exactly NCOL+2 = 8 cycles apart.
- With INV_MIX_COLUMNS_FWD_SEL_EN, NCOL=4: in_fwd=1, {db135345,f20a225c,01010101,c6c6c6c6} -> {8e4da1bc,9fdc589d,01010101,c6c6c6c6}; feeding that output back with in_fwd=0 -> original block.
